// File: rtl/toggle_activity_monitor_if.sv
// Control, monitored-signal and readout-stream bundle for toggle_activity_monitor.
// master drives start/window/sig_in/rd_ready; slave is the monitor itself.
interface toggle_activity_monitor_if #(
   parameter int NUM_SIG = 4,
   parameter int CNT_W   = 16,
   parameter int WIN_W   = 16,
   parameter int IDX_W   = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1,
   parameter int TOT_W   = CNT_W + IDX_W + 1
);
   logic               start;
   logic [WIN_W-1:0]   window_len;
   logic [NUM_SIG-1:0] sig_in;
   logic               busy;
   logic               rd_valid;
   logic               rd_ready;
   logic [IDX_W-1:0]   rd_idx;
   logic [CNT_W-1:0]   rd_count;
   logic               rd_last;
   logic [TOT_W-1:0]   total_count;
   logic               done;

   modport master (
      output start, window_len, sig_in, rd_ready,
      input  busy, rd_valid, rd_idx, rd_count, rd_last, total_count, done
   );

   modport slave (
      input  start, window_len, sig_in, rd_ready,
      output busy, rd_valid, rd_idx, rd_count, rd_last, total_count, done
   );
endinterface

// File: rtl/toggle_activity_monitor.sv
// Counts per-signal transitions over a programmed window of clock cycles, then
// streams the per-signal counts out over valid/ready with a saturating total.
module toggle_activity_monitor #(
   parameter int NUM_SIG = 4,
   parameter int CNT_W   = 16,
   parameter int WIN_W   = 16,
   parameter int IDX_W   = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1,
   parameter int TOT_W   = CNT_W + IDX_W + 1
) (
   input logic                      clk,
   input logic                      rst,
   toggle_activity_monitor_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ARM, COUNT, DUMP} state_t;

   state_t                        state, state_nx;
   logic [WIN_W-1:0]              remaining;
   logic [NUM_SIG-1:0]            prev, tog;
   logic [NUM_SIG-1:0][CNT_W-1:0] cnt;
   logic [TOT_W-1:0]              total, pop;
   logic [TOT_W:0]                total_sum;
   logic [IDX_W-1:0]              idx;
   logic                          done_q;
   logic                          accept, hs, last;

   assign accept = (state == IDLE) && bus.start && (bus.window_len != '0);
   assign hs     = (state == DUMP) && bus.rd_ready;
   assign last   = (idx == IDX_W'(NUM_SIG - 1));
   assign tog    = bus.sig_in ^ prev;

   // Extra carry bit makes total overflow detectable so it can pin at all-ones.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_SIG; i++) pop = pop + TOT_W'(tog[i]);
      total_sum = {1'b0, total} + {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = ARM;
         ARM:     state_nx = COUNT;
         COUNT:   if (remaining == WIN_W'(1)) state_nx = DUMP;
         DUMP:    if (hs && last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         remaining <= '0;
         prev      <= '0;
         cnt       <= '0;
         total     <= '0;
         idx       <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= hs && last;
         case (state)
            IDLE: if (accept) begin
               remaining <= bus.window_len;
               cnt       <= '0;
               total     <= '0;
               idx       <= '0;
            end
            ARM: prev <= bus.sig_in;
            COUNT: begin
               prev      <= bus.sig_in;
               remaining <= remaining - WIN_W'(1);
               for (int i = 0; i < NUM_SIG; i++)
                  if (tog[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
               total <= total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
            end
            DUMP: if (hs) idx <= last ? '0 : idx + IDX_W'(1);
            default: ;
         endcase
      end
   end

   assign bus.busy        = (state != IDLE);
   assign bus.rd_valid    = (state == DUMP);
   assign bus.rd_idx      = idx;
   assign bus.rd_count    = cnt[idx];
   assign bus.rd_last     = (state == DUMP) && last;
   assign bus.total_count = total;
   assign bus.done        = done_q;
endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Directed bench: a per-window model pushes expected readout words to a scoreboard,
// popped and compared at each readout handshake.
module tb_toggle_activity_monitor;
   localparam int NS = 2;
   localparam int CW = 4;
   localparam int WW = 8;
   localparam int IW = 1;
   localparam int TW = CW + IW + 1;

   typedef struct {
      logic [IW-1:0] idx;
      logic [CW-1:0] cnt;
      logic          last;
   } word_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   toggle_activity_monitor_if #(.NUM_SIG(NS), .CNT_W(CW), .WIN_W(WW), .IDX_W(IW), .TOT_W(TW)) bus ();

   toggle_activity_monitor #(.NUM_SIG(NS), .CNT_W(CW), .WIN_W(WW), .IDX_W(IW), .TOT_W(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   word_t          sb [$];
   logic [TW-1:0]  exp_total;
   logic [NS-1:0]  seq [0:63];
   int             n_pass = 0;
   int             n_total = 0;
   int             done_cnt = 0;

   always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Model: count transitions between consecutive samples seq[0..w], saturating.
   task automatic run_window(input int w, input int inj);
      int    c [NS];
      int    t;
      word_t wd;
      t = 0;
      for (int i = 0; i < NS; i++) c[i] = 0;
      for (int k = 1; k <= w; k++)
         for (int i = 0; i < NS; i++)
            if (seq[k][i] !== seq[k-1][i]) begin c[i]++; t++; end
      for (int i = 0; i < NS; i++) begin
         wd.idx  = IW'(i);
         wd.cnt  = (c[i] > 15) ? {CW{1'b1}} : CW'(c[i]);
         wd.last = (i == NS - 1);
         sb.push_back(wd);
      end
      exp_total = (t > 63) ? {TW{1'b1}} : TW'(t);
      @(negedge clk); bus.start = 1'b1; bus.window_len = WW'(w);
      @(negedge clk); bus.start = 1'b0; bus.window_len = '0; bus.sig_in = seq[0];
      check("arm_busy", 32'(bus.busy), 1);
      for (int k = 1; k <= w; k++) begin
         @(negedge clk);
         bus.sig_in     = seq[k];
         bus.start      = (k == inj);
         bus.window_len = (k == inj) ? WW'(2) : '0;
         check("count_flags", 32'({bus.busy, bus.rd_valid}), 32'b10);
      end
      @(negedge clk); bus.start = 1'b0;
   endtask

   task automatic drain(input int stall);
      int    cyc;
      int    d0;
      int    s;
      word_t wd;
      cyc = 0;
      s   = stall;
      d0  = done_cnt;
      check("dump_valid", 32'(bus.rd_valid), 1);
      check("total", 32'(bus.total_count), 32'(exp_total));
      while (sb.size() > 0 && cyc < 200) begin
         if (s > 0) begin
            bus.rd_ready = 1'b0;
            check("stall_valid", 32'(bus.rd_valid), 1);
            check("stall_idx", 32'(bus.rd_idx), 32'(sb[0].idx));
            check("stall_cnt", 32'(bus.rd_count), 32'(sb[0].cnt));
            s--;
         end else begin
            bus.rd_ready = 1'b1;
            if (bus.rd_valid === 1'b1) begin
               wd = sb.pop_front();
               check("rd_idx", 32'(bus.rd_idx), 32'(wd.idx));
               check("rd_count", 32'(bus.rd_count), 32'(wd.cnt));
               check("rd_last", 32'(bus.rd_last), 32'(wd.last));
            end else begin
               check("valid_drop", 32'(bus.rd_valid), 1);
            end
         end
         @(negedge clk);
         cyc++;
      end
      bus.rd_ready = 1'b0;
      if (cyc >= 200) begin
         check("drain_timeout", 0, 1);
         sb.delete();
      end
      check("done_pulse", 32'(bus.done), 1);
      check("idle_busy", 32'(bus.busy), 0);
      @(negedge clk);
      check("done_clear", 32'(bus.done), 0);
      @(negedge clk);
      check("done_once", 32'(done_cnt - d0), 1);
   endtask

   initial begin
      int d0;
      rst = 1'b1;
      bus.start = 1'b0; bus.window_len = '0; bus.sig_in = '0; bus.rd_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_valid", 32'(bus.rd_valid), 0);
      check("rst_last", 32'(bus.rd_last), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_idx", 32'(bus.rd_idx), 0);
      check("rst_total", 32'(bus.total_count), 0);
      rst = 1'b0;
      @(negedge clk);

      // sig0 toggles every cycle, sig1 constant 0
      for (int k = 0; k < 64; k++) seq[k] = {1'b0, k[0]};
      run_window(10, -1);
      drain(0);

      // sig0 toggles for 5 cycles then holds, sig1 constant 1
      for (int k = 0; k < 64; k++) seq[k] = {1'b1, (k <= 5) ? k[0] : 1'b1};
      run_window(12, -1);
      drain(0);

      // both toggle for 20 comparisons: per-signal counts saturate, with a 3-cycle stall
      for (int k = 0; k < 64; k++) seq[k] = {~k[0], k[0]};
      run_window(20, -1);
      drain(3);

      // 80 toggles total pins the total at its maximum
      run_window(40, -1);
      drain(0);

      // reset during the 4th COUNT cycle aborts the measurement
      d0 = done_cnt;
      @(negedge clk); bus.start = 1'b1; bus.window_len = WW'(10);
      @(negedge clk); bus.start = 1'b0; bus.window_len = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.sig_in = ~bus.sig_in;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_valid", 32'(bus.rd_valid), 0);
      check("abort_done", 32'(bus.done), 0);
      repeat (3) @(negedge clk);
      check("abort_no_done", 32'(done_cnt - d0), 0);
      check("abort_idle", 32'(bus.busy), 0);

      // fresh window after the abort starts from zero
      for (int k = 0; k < 64; k++) seq[k] = {1'b1, k[0]};
      run_window(3, -1);
      drain(0);

      // start with window_len=0 in IDLE is ignored
      @(negedge clk); bus.start = 1'b1; bus.window_len = '0;
      @(negedge clk); bus.start = 1'b0;
      check("zero_win_busy", 32'(bus.busy), 0);
      @(negedge clk);
      check("zero_win_busy2", 32'(bus.busy), 0);

      // start pulsed mid-COUNT is ignored
      for (int k = 0; k < 64; k++) seq[k] = {k[1], k[0]};
      run_window(8, 3);
      drain(0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
